act_capture_fifo: RTL

Downstream capture stage for the nested-loop step sequencer's act1/act2 outputs.
- Detects every change on act1 and pushes the pair {act2, act1} into a small FIFO.
- Drains the FIFO over a valid/ready stream.
- Keeps statistics: dropped entries, act1≠act2 mismatches, and completed frames (act2 returning to 0).

---
 rtl/act_capture_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/act_capture_fifo.sv
// act_capture_fifo: captures every act1 change as {act2, act1} into a small FIFO
// drained over valid/ready, and keeps drop/mismatch/frame statistics.
// Optional build macro ACT_CAP_TIMESTAMP_EN prepends a 16-bit cycle timestamp
// to every captured word.
module act_capture_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       act1_i,
    input  logic [DW-1:0]       act2_i,
    input  logic                clr_i,
    output logic                m_valid,
    input  logic                m_ready,
`ifdef ACT_CAP_TIMESTAMP_EN
    output logic [2*DW+15:0]    m_data,
`else
    output logic [2*DW-1:0]     m_data,
`endif
    output logic [AW:0]         fifo_count,
    output logic [7:0]          drop_cnt,
    output logic [7:0]          mismatch_cnt,
    output logic                frame_done,
    output logic [7:0]          frame_cnt
);

`ifdef ACT_CAP_TIMESTAMP_EN
    localparam int unsigned TSW = 16;
    localparam int unsigned MW  = 2 * DW + TSW;
`else
    localparam int unsigned MW  = 2 * DW;
`endif

    logic [DW-1:0] act1_q;
    logic [DW-1:0] act2_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [MW-1:0] mem [DEPTH];

    logic          evt_c;
    logic          frame_evt_c;
    logic          full_c;
    logic          pop_c;
    logic          push_c;
    logic          drop_c;
    logic          mism_c;
    logic [MW-1:0] wr_word_c;

`ifdef ACT_CAP_TIMESTAMP_EN
    logic [TSW-1:0] ts_q;

    // Free-running cycle stamp, restarted by reset and clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (clr_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TSW'(1);
        end
    end

    assign wr_word_c = {ts_q, act2_i, act1_i};
`else
    assign wr_word_c = {act2_i, act1_i};
`endif

    // Event detection and push/pop/drop decisions; clear discards all of them
    always_comb begin
        evt_c       = (act1_i != act1_q);
        frame_evt_c = (act2_q != '0) && (act2_i == '0);
        full_c      = (fifo_count == (AW+1)'(DEPTH));
        pop_c       = m_valid && m_ready && !clr_i;
        push_c      = evt_c && !clr_i && (!full_c || pop_c);
        drop_c      = evt_c && !clr_i && full_c && !pop_c;
        mism_c      = evt_c && !clr_i && (act1_i != act2_i);
    end

    // Input history, tracked every cycle (clear included) so clear never fakes an event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act1_q <= '0;
            act2_q <= '0;
        end else begin
            act1_q <= act1_i;
            act2_q <= act2_i;
        end
    end

    // Storage array; contents need no reset since m_valid qualifies them
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= wr_word_c;
        end
    end

    // Pointers and occupancy; a push into a full FIFO only lands when a pop frees a slot
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Statistics: saturating drop/mismatch counters, wrapping frame counter with pulse
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            drop_cnt     <= '0;
            mismatch_cnt <= '0;
            frame_cnt    <= '0;
            frame_done   <= 1'b0;
        end else begin
            if (drop_c && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (mism_c && (mismatch_cnt != 8'hFF)) begin
                mismatch_cnt <= mismatch_cnt + 8'd1;
            end
            if (frame_evt_c) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            frame_done <= frame_evt_c;
        end
    end

    // Head of queue straight from the read pointer
    assign m_valid = (fifo_count != '0);
    assign m_data  = mem[rd_ptr];

endmodule
